// File: rtl/karatsuba_divider.sv
// ----------------------------------------------------------------------------
// karatsuba_divider
//   Sequential restoring divider. Divides a 2*WIDTH-bit unsigned dividend by a
//   WIDTH-bit unsigned divisor and produces one quotient bit per clock. The
//   operand and result sides each use a valid/ready handshake, and only one
//   operation is in flight at a time.
//
//   Optional build macro: DIVIDER_EARLY_EXIT_EN
//     When defined, the leading zeros of the dividend are skipped at acceptance.
//     A zero dividend then completes straight away. Results are bit-identical
//     to the default build; only the latency changes.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands valid
//   in_ready     block can accept operands (high only in IDLE)
//   dividend     2*WIDTH-bit numerator
//   divisor      WIDTH-bit denominator
//   out_valid    result valid (high only in DONE)
//   out_ready    consumer accepts result
//   quotient     2*WIDTH-bit dividend / divisor (all ones on divide by zero)
//   remainder    WIDTH-bit dividend % divisor (dividend[WIDTH-1:0] on /0)
//   div_by_zero  result came from a divisor == 0 operation
// ----------------------------------------------------------------------------
module karatsuba_divider #(
    parameter int WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [DW-1:0]    r_dvd;       // dividend bits shift out the top, quotient bits shift in at the bottom
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;       // partial remainder is always < divisor, so WIDTH bits hold it
    logic [CW-1:0]    r_cnt;
    logic [DW-1:0]    r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_partial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [DW-1:0]    w_dvd_next;
    logic [CW-1:0]    w_last_cnt;

    // One restoring step. The partial value is below 2*divisor, so the sign
    // bit of the (WIDTH+1)-bit difference is exactly the "partial < divisor" flag.
    assign w_partial  = {r_rem, r_dvd[DW-1]};
    assign w_diff     = w_partial - {1'b0, r_dvs};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
    assign w_dvd_next = {r_dvd[DW-2:0], w_ge};

`ifdef DIVIDER_EARLY_EXIT_EN
    logic [CW-1:0] r_last;
    logic [CW-1:0] w_lz;
    logic [DW-1:0] w_dvd_init;
    logic [CW-1:0] w_last;
    logic          w_dvd_zero;

    // Leading-zero count: the highest set bit wins since it is assigned last.
    always_comb begin
        w_lz = CW'(DW);
        for (int i = 0; i < DW; i++) begin
            if (dividend[i]) w_lz = CW'(DW - 1 - i);
        end
    end

    assign w_dvd_init = dividend << w_lz;
    assign w_last     = CW'(DW) - w_lz - 1'b1;
    assign w_dvd_zero = (w_lz == CW'(DW));
    assign w_last_cnt = r_last;
`else
    assign w_last_cnt = CW'(DW - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef DIVIDER_EARLY_EXIT_EN
            r_last      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rem <= '0;
                        r_cnt <= '0;
                        r_dvs <= divisor;
                        if (divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend[WIDTH-1:0];
                            r_dbz       <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
`ifdef DIVIDER_EARLY_EXIT_EN
                            if (w_dvd_zero) begin
                                r_quotient  <= '0;
                                r_remainder <= '0;
                                r_dbz       <= 1'b0;
                                r_state     <= S_DONE;
                            end else begin
                                r_dvd   <= w_dvd_init;
                                r_last  <= w_last;
                                r_state <= S_CALC;
                            end
`else
                            r_dvd   <= dividend;
                            r_state <= S_CALC;
`endif
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt + 1'b1;
                    // Final step: publish its outcome directly into the result registers.
                    if (r_cnt == w_last_cnt) begin
                        r_quotient  <= w_dvd_next;
                        r_remainder <= w_rem_next;
                        r_dbz       <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_karatsuba_divider.sv
// ----------------------------------------------------------------------------
// tb_karatsuba_divider
//   Scoreboard bench for karatsuba_divider at WIDTH=8. Expected results are
//   computed from a behavioural model when operands are driven, queued, and
//   compared when out_valid is seen. Also covers reset state, backpressure
//   and reset in the middle of a calculation.
// ----------------------------------------------------------------------------
module tb_karatsuba_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb_q[$];

    karatsuba_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference model: plain integer division plus the expected latency.
    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t e;
        int   n;
        n = 16;
`ifdef DIVIDER_EARLY_EXIT_EN
        n = 0;
        for (int i = 0; i < 16; i++) if (dvd[i]) n = i + 1;
`endif
        if (dvs == 8'd0) begin
            e.q   = 16'hFFFF;
            e.r   = dvd[7:0];
            e.dbz = 1'b1;
            e.lat = 8'd1;
        end else begin
            e.q   = dvd / {8'd0, dvs};
            e.r   = 8'(dvd % {8'd0, dvs});
            e.dbz = 1'b0;
            e.lat = (n == 0) ? 8'd1 : 8'(n + 1);
        end
        return e;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait for its result, compare, optionally hold
    // out_ready low for 'hold' cycles, then consume the result.
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, input int hold);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        sb_q.push_back(model(dvd, dvs));
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb_q.pop_front();
        if (!out_valid) begin
            chk("timeout", {31'd0, out_valid}, 32'd1);
            apply_reset();
            return;
        end
        $display("op %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", dvd, dvs, quotient, remainder,
                 div_by_zero, cyc + 1);
        chk("latency", 32'(cyc + 1), {24'd0, e.lat});
        chk("quotient", {16'd0, quotient}, {16'd0, e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, e.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_q", {16'd0, quotient}, {16'd0, e.q});
            chk("hold_r", {24'd0, remainder}, {24'd0, e.r});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop", {31'd0, out_valid}, 32'd0);
        chk("ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {24'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(16'd1000, 8'd7, 0);
        run_op(16'h1234, 8'h00, 0);
        run_op(16'hFFFF, 8'hFF, 5);
        run_op(16'd5, 8'd2, 0);
        run_op(16'd0, 8'd9, 0);
        run_op(16'd0, 8'd0, 0);
        run_op(16'h00FF, 8'hFF, 0);
        run_op(16'hFFFF, 8'h01, 0);

        // Abort an operation mid-calculation; the previous result is non-zero.
        in_valid = 1'b1;
        dividend = 16'd200;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_quotient", {16'd0, quotient}, 32'd0);
        chk("midrst_remainder", {24'd0, remainder}, 32'd0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_no_result", {31'd0, out_valid}, 32'd0);
        run_op(16'd50, 8'd3, 0);

        for (int k = 0; k < 24; k++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom);
            b = (k % 6 == 5) ? 8'd0 : 8'($urandom);
            if (k % 4 == 3) a = a >> $urandom_range(15, 4);
            run_op(a, b, (k % 5 == 0) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
